// File: rtl/rst_sequencer.sv
// Staged reset release sequencer: holds all downstream resets while a request is
// active, then releases domains 0..NSTAGE-1 one at a time, each gated by its ack.
module rst_sequencer #(
  parameter int NSTAGE  = 3,
  parameter int HOLD    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              irst,
  input  logic              ireq,
  input  logic [NSTAGE-1:0] iack,
  output logic [NSTAGE-1:0] orst,
  output logic              oready,
  output logic              oerr
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NSTAGE - 1);

  typedef enum logic [2:0] {
    S_ASSERT,
    S_HOLD,
    S_REL,
    S_WAITACK,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NSTAGE-1:0] orst_q, orst_d;
  logic              oready_q, oready_d;
  logic              oerr_q, oerr_d;

  // One-hot decode of the current stage; used both to pick the one ack we
  // listen to and to clear exactly one reset bit when leaving REL.
  logic [NSTAGE-1:0] stage_sel;
  logic              ack_sel;

  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_sel
      assign stage_sel[gi] = (idx_q == IW'(gi));
    end
  endgenerate

  assign ack_sel = |(iack & stage_sel);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    orst_d     = orst_q;
    oready_d   = oready_q;
    oerr_d     = oerr_q;

    if (ireq) begin
      // A request restarts the whole sequence from any state; oerr is kept.
      state_d    = S_ASSERT;
      hold_cnt_d = '0;
      timer_d    = '0;
      idx_d      = '0;
      orst_d     = '1;
      oready_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_ASSERT: begin
          orst_d     = '1;
          oready_d   = 1'b0;
          hold_cnt_d = '0;
          state_d    = S_HOLD;
        end

        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = S_REL;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end

        S_REL: begin
          orst_d  = orst_q & ~stage_sel;
          timer_d = '0;
          state_d = S_WAITACK;
        end

        S_WAITACK: begin
          if (ack_sel) begin
            if (idx_q == IDX_LAST) begin
              state_d  = S_DONE;
              oready_d = 1'b1;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = S_REL;
            end
          end else if (timer_q == TMO_LAST) begin
            // Stage never came alive: flag it, re-assert everything and retry
            // through a full HOLD period.
            oerr_d     = 1'b1;
            orst_d     = '1;
            oready_d   = 1'b0;
            idx_d      = '0;
            timer_d    = '0;
            hold_cnt_d = '0;
            state_d    = S_ASSERT;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        S_DONE: begin
          orst_d   = '0;
          oready_d = 1'b1;
        end

        default: begin
          state_d    = S_ASSERT;
          orst_d     = '1;
          oready_d   = 1'b0;
          idx_d      = '0;
          timer_d    = '0;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (irst) begin
      state_q    <= S_ASSERT;
      hold_cnt_q <= '0;
      timer_q    <= '0;
      idx_q      <= '0;
      orst_q     <= '1;
      oready_q   <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      orst_q     <= orst_d;
      oready_q   <= oready_d;
      oerr_q     <= oerr_d;
    end
  end

  assign orst   = orst_q;
  assign oready = oready_q;
  assign oerr   = oerr_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios plus randomized traffic, all checked
// against a count-based model of the release sequence.
module tb_rst_sequencer;

  localparam int NSTAGE  = 3;
  localparam int HOLD    = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              irst;
  logic              ireq;
  logic [NSTAGE-1:0] iack;
  logic [NSTAGE-1:0] orst;
  logic              oready;
  logic              oerr;

  int total = 0;
  int bad   = 0;

  // Model: settle = clean low edges since restart, rel = stages released so far.
  int m_settle;
  int m_wait;
  int m_rel;
  bit m_due;
  bit m_waiting;
  bit m_done;
  bit m_err;

  rst_sequencer #(
    .NSTAGE (NSTAGE),
    .HOLD   (HOLD),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .irst  (irst),
    .ireq  (ireq),
    .iack  (iack),
    .orst  (orst),
    .oready(oready),
    .oerr  (oerr)
  );

  function automatic logic [NSTAGE-1:0] exp_orst();
    logic [NSTAGE-1:0] r;
    r = '1;
    for (int i = 0; i < NSTAGE; i++) if (i < m_rel) r[i] = 1'b0;
    return r;
  endfunction

  task automatic model_restart();
    m_settle  = 0;
    m_wait    = 0;
    m_rel     = 0;
    m_due     = 0;
    m_waiting = 0;
    m_done    = 0;
  endtask

  task automatic model_step(input logic r, input logic q, input logic [NSTAGE-1:0] a);
    if (r) begin
      m_err = 0;
      model_restart();
    end else if (q) begin
      model_restart();
    end else if (m_done) begin
      // stays released
    end else if (m_due) begin
      m_due     = 0;
      m_rel     = m_rel + 1;
      m_waiting = 1;
      m_wait    = 0;
    end else if (m_waiting) begin
      if (a[m_rel-1]) begin
        m_waiting = 0;
        if (m_rel == NSTAGE) m_done = 1;
        else m_due = 1;
      end else if (m_wait == TIMEOUT) begin
        m_err = 1;
        model_restart();
      end else begin
        m_wait = m_wait + 1;
      end
    end else begin
      m_settle = m_settle + 1;
      if (m_settle == HOLD + 1) m_due = 1;
    end
  endtask

  // Advance one edge; inputs were driven 1 time unit after the previous edge.
  task automatic cycle();
    @(posedge clk);
    model_step(irst, ireq, iack);
    #1;
  endtask

  task automatic test_reset();
    irst = 1'b1;
    ireq = 1'($urandom);
    iack = NSTAGE'($urandom);
    cycle();
    cycle();
    total++;
    if (orst !== {NSTAGE{1'b1}}) begin
      bad++;
      $display("FAIL reset_orst got=%b want=%b", orst, {NSTAGE{1'b1}});
    end
    total++;
    if (oready !== 1'b0) begin
      bad++;
      $display("FAIL reset_oready got=%b want=0", oready);
    end
    total++;
    if (oerr !== 1'b0) begin
      bad++;
      $display("FAIL reset_oerr got=%b want=0", oerr);
    end
    $display("test_reset: orst=%b oready=%b oerr=%b", orst, oready, oerr);
  endtask

  task automatic test_power_up();
    logic [NSTAGE-1:0] prev;
    int fall0, rdy;
    irst  = 1'b0;
    ireq  = 1'b0;
    iack  = '0;
    prev  = '1;
    fall0 = -1;
    rdy   = -1;
    for (int e = 1; e <= 40 && rdy < 0; e++) begin
      cycle();
      if (fall0 < 0 && orst[0] === 1'b0) fall0 = e;
      if (oready === 1'b1) rdy = e;
      total++;
      if (orst !== exp_orst() || oready !== m_done || oerr !== m_err) begin
        bad++;
        $display("FAIL powerup_model edge=%0d got orst=%b rdy=%b err=%b want orst=%b rdy=%b err=%b",
                 e, orst, oready, oerr, exp_orst(), m_done, m_err);
      end
      iack = ~prev;
      prev = orst;
    end
    total++;
    if (fall0 != HOLD + 2) begin
      bad++;
      $display("FAIL powerup_orst0_edge got=%0d want=%0d", fall0, HOLD + 2);
    end
    total++;
    if (rdy < 0 || orst !== '0 || oerr !== 1'b0) begin
      bad++;
      $display("FAIL powerup_done got rdy_edge=%0d orst=%b oerr=%b want ready, orst=0, oerr=0",
               rdy, orst, oerr);
    end
    $display("test_power_up: orst0 fell at edge %0d, ready at edge %0d", fall0, rdy);
  endtask

  task automatic test_ireq_in_done();
    logic [NSTAGE-1:0] prev;
    int rdy;
    ireq = 1'b1;
    cycle();
    total++;
    if (orst !== {NSTAGE{1'b1}} || oready !== 1'b0) begin
      bad++;
      $display("FAIL ireq_done_assert got orst=%b oready=%b want orst=%b oready=0",
               orst, oready, {NSTAGE{1'b1}});
    end
    ireq = 1'b0;
    iack = '0;
    prev = orst;
    rdy  = -1;
    for (int e = 1; e <= 40 && rdy < 0; e++) begin
      cycle();
      if (oready === 1'b1) rdy = e;
      total++;
      if (orst !== exp_orst() || oready !== m_done || oerr !== m_err) begin
        bad++;
        $display("FAIL ireq_done_model edge=%0d got orst=%b rdy=%b err=%b want orst=%b rdy=%b err=%b",
                 e, orst, oready, oerr, exp_orst(), m_done, m_err);
      end
      iack = ~prev;
      prev = orst;
    end
    total++;
    if (rdy < 0 || oerr !== 1'b0) begin
      bad++;
      $display("FAIL ireq_done_reseq got rdy_edge=%0d oerr=%b want ready and oerr=0", rdy, oerr);
    end
    $display("test_ireq_in_done: resequenced, ready at edge %0d", rdy);
  endtask

  task automatic test_timeout();
    int err_edge, refall;
    logic [NSTAGE-1:0] orst_at_err;
    irst = 1'b1;
    ireq = 1'b0;
    iack = '0;
    cycle();
    irst        = 1'b0;
    err_edge    = -1;
    refall      = -1;
    orst_at_err = '0;
    for (int e = 1; e <= 40; e++) begin
      cycle();
      if (err_edge < 0 && oerr === 1'b1) begin
        err_edge    = e;
        orst_at_err = orst;
      end
      if (err_edge > 0 && refall < 0 && e > err_edge && orst[0] === 1'b0) refall = e;
      total++;
      if (orst !== exp_orst() || oready !== m_done || oerr !== m_err) begin
        bad++;
        $display("FAIL timeout_model edge=%0d got orst=%b rdy=%b err=%b want orst=%b rdy=%b err=%b",
                 e, orst, oready, oerr, exp_orst(), m_done, m_err);
      end
      iack = ~orst & 3'b101;
    end
    // stage 0 acks one edge after release, stage 1 falls 2 edges later and
    // then waits TIMEOUT+1 cycles
    total++;
    if (err_edge != HOLD + 2 + 2 + TIMEOUT + 1) begin
      bad++;
      $display("FAIL timeout_edge got=%0d want=%0d", err_edge, HOLD + 2 + 2 + TIMEOUT + 1);
    end
    total++;
    if (orst_at_err !== {NSTAGE{1'b1}}) begin
      bad++;
      $display("FAIL timeout_orst got=%b want=%b", orst_at_err, {NSTAGE{1'b1}});
    end
    total++;
    if (refall != err_edge + HOLD + 2) begin
      bad++;
      $display("FAIL timeout_retry_edge got=%0d want=%0d", refall, err_edge + HOLD + 2);
    end
    total++;
    if (oerr !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky got=%b want=1", oerr);
    end
    irst = 1'b1;
    cycle();
    irst = 1'b0;
    total++;
    if (oerr !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear got=%b want=0", oerr);
    end
    $display("test_timeout: oerr at edge %0d, retry release at edge %0d", err_edge, refall);
  endtask

  task automatic test_ireq_glitch();
    int fall0;
    bit early;
    irst  = 1'b1;
    ireq  = 1'b0;
    iack  = '0;
    cycle();
    irst  = 1'b0;
    fall0 = -1;
    early = 0;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      if (fall0 < 0 && orst[0] === 1'b0) fall0 = e;
      if (e < 10 && orst !== {NSTAGE{1'b1}}) early = 1;
      total++;
      if (orst !== exp_orst() || oready !== m_done) begin
        bad++;
        $display("FAIL glitch_model edge=%0d got orst=%b rdy=%b want orst=%b rdy=%b",
                 e, orst, oready, exp_orst(), m_done);
      end
      ireq = (e == 3);
    end
    total++;
    if (early || fall0 != 4 + HOLD + 2) begin
      bad++;
      $display("FAIL glitch_release got fall_edge=%0d early_drop=%0d want fall_edge=%0d early_drop=0",
               fall0, early, 4 + HOLD + 2);
    end
    $display("test_ireq_glitch: orst0 fell at edge %0d", fall0);
  endtask

  task automatic test_all_ack();
    int fall[NSTAGE];
    int rdy;
    irst = 1'b1;
    ireq = 1'b0;
    iack = '1;
    cycle();
    irst = 1'b0;
    rdy  = -1;
    for (int i = 0; i < NSTAGE; i++) fall[i] = -1;
    for (int e = 1; e <= 14; e++) begin
      cycle();
      for (int i = 0; i < NSTAGE; i++) if (fall[i] < 0 && orst[i] === 1'b0) fall[i] = e;
      if (rdy < 0 && oready === 1'b1) rdy = e;
    end
    for (int i = 0; i < NSTAGE; i++) begin
      total++;
      if (fall[i] != HOLD + 2 + 2 * i) begin
        bad++;
        $display("FAIL allack_fall%0d got=%0d want=%0d", i, fall[i], HOLD + 2 + 2 * i);
      end
    end
    total++;
    if (rdy != HOLD + 2 + 2 * (NSTAGE - 1) + 1) begin
      bad++;
      $display("FAIL allack_ready got=%0d want=%0d", rdy, HOLD + 2 + 2 * (NSTAGE - 1) + 1);
    end
    $display("test_all_ack: ready at edge %0d", rdy);
  endtask

  task automatic test_random();
    logic [NSTAGE-1:0] inv;
    logic              prev_err;
    logic              rst_now;
    prev_err = oerr;
    for (int n = 0; n < 1500; n++) begin
      irst = ($urandom_range(0, 99) < 2);
      ireq = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) < 7) iack = ~orst;
      else iack = NSTAGE'($urandom);
      rst_now = irst;
      cycle();
      total++;
      if (orst !== exp_orst() || oready !== m_done || oerr !== m_err) begin
        bad++;
        $display("FAIL random_model n=%0d got orst=%b rdy=%b err=%b want orst=%b rdy=%b err=%b",
                 n, orst, oready, oerr, exp_orst(), m_done, m_err);
      end
      inv = ~orst;
      total++;
      if ((inv & (inv + 1'b1)) !== '0) begin
        bad++;
        $display("FAIL random_thermo n=%0d got orst=%b want thermometer code", n, orst);
      end
      total++;
      if (oready === 1'b1 && orst !== '0) begin
        bad++;
        $display("FAIL random_ready n=%0d got orst=%b with oready=1 want orst=0", n, orst);
      end
      total++;
      if (!rst_now && prev_err === 1'b1 && oerr !== 1'b1) begin
        bad++;
        $display("FAIL random_err_sticky n=%0d got=%b want=1", n, oerr);
      end
      prev_err = oerr;
    end
    $display("test_random: 1500 cycles, final orst=%b oready=%b oerr=%b", orst, oready, oerr);
  endtask

  initial begin
    irst  = 1'b1;
    ireq  = 1'b0;
    iack  = '0;
    m_err = 0;
    model_restart();
    #1;
    test_reset();
    test_power_up();
    test_ireq_in_done();
    test_timeout();
    test_ireq_glitch();
    test_all_ack();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
